// File: rtl/adder_4bit.sv
// Registered ripple-carry adder: {cout, s} = a + b + cin with a signed-overflow flag.
// The full-adder chain is purely combinational; one register stage gives a latency of one clock.
module adder_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic             cout,
    output logic [WIDTH-1:0] s,
    output logic             ovf
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    assign carry[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign sum_comb[gi]  = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1]   = (a[gi] & b[gi]) | (a[gi] & carry[gi]) | (b[gi] & carry[gi]);
        end
    endgenerate

    logic [WIDTH-1:0] s_d, s_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;
    logic             out_valid_d, out_valid_q;

    // Idle cycles keep the last result, so operand bits are never looked at unless in_valid is set.
    always_comb begin
        s_d         = s_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            s_d         = sum_comb;
            cout_d      = carry[WIDTH];
            ovf_d       = carry[WIDTH] ^ carry[WIDTH-1];
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s_q         <= s_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder_4bit.sv
// Bench for adder_4bit: directed cases, async reset, hold-on-idle, then a shuffled exhaustive sweep
// and random traffic, all scored against an integer-arithmetic reference.
module tb_adder_4bit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       cin;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       cout;
    logic [3:0] s;
    logic       ovf;

    int tests_run = 0;
    int tests_failed = 0;

    // Expected register contents after the next clock edge.
    logic       exp_valid = 1'b0;
    logic [3:0] exp_s = '0;
    logic       exp_cout = 1'b0;
    logic       exp_ovf = 1'b0;

    adder_4bit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .cin       (cin),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .cout      (cout),
        .s         (s),
        .ovf       (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
        check({tag, ".s"},         32'(s),         32'(exp_s));
        check({tag, ".cout"},      32'(cout),      32'(exp_cout));
        check({tag, ".ovf"},       32'(ovf),       32'(exp_ovf));
    endtask

    // Reference: unsigned sum for s/cout, signed sum range test for ovf.
    task automatic model(input logic [3:0] ma, input logic [3:0] mb, input logic mc);
        int full;
        int sa;
        int sb;
        int sres;
        full = int'(ma) + int'(mb) + int'(mc);
        sa   = (ma >= 8) ? int'(ma) - 16 : int'(ma);
        sb   = (mb >= 8) ? int'(mb) - 16 : int'(mb);
        sres = sa + sb + int'(mc);
        exp_valid = 1'b1;
        exp_s     = 4'(full % 16);
        exp_cout  = (full >= 16);
        exp_ovf   = (sres > 7) || (sres < -8);
    endtask

    // One clock: check the result of the previous cycle's inputs, then drive the next inputs.
    task automatic step(input string tag, input logic v, input logic c,
                        input logic [3:0] sa_in, input logic [3:0] sb_in);
        @(posedge clk);
        #1;
        check_outputs(tag);
        if (v) model(sa_in, sb_in, c);
        else   exp_valid = 1'b0;
        in_valid = v;
        cin      = c;
        a        = sa_in;
        b        = sb_in;
        $display("[TB] %s v=%0b cin=%0b a=%0h b=%0h -> exp s=%0h cout=%0b ovf=%0b", tag, v, c, sa_in, sb_in,
                 exp_s, exp_cout, exp_ovf);
    endtask

    int order[512];

    initial begin
        in_valid = 1'b0;
        cin      = 1'b0;
        a        = '0;
        b        = '0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_outputs("reset_async");
        #10 rst_n = 1'b1;

        step("zero_add",  1, 0, 4'h0, 4'h0);
        step("add_2_3",   1, 0, 4'h2, 4'h3);
        step("add_2_3_c", 1, 1, 4'h2, 4'h3);
        step("add_0_0_c", 1, 1, 4'h0, 4'h0);
        step("sat_f_f",   1, 0, 4'hF, 4'hF);
        step("sat_f_f_c", 1, 1, 4'hF, 4'hF);
        step("ovf_7_1",   1, 0, 4'h7, 4'h1);
        step("ovf_8_8",   1, 0, 4'h8, 4'h8);
        step("add_2_3b",  1, 0, 4'h2, 4'h3);
        step("hold_x",    0, 1'bx, 4'bxxxx, 4'bxxxx);
        step("hold_x2",   0, 1'bx, 4'bxxxx, 4'bxxxx);
        step("pending",   1, 1, 4'h9, 4'h4);

        // Reset pulse between edges discards the pending result.
        @(posedge clk);
        #1;
        check_outputs("pre_reset");
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        exp_valid = 1'b0;
        exp_s     = '0;
        exp_cout  = 1'b0;
        exp_ovf   = 1'b0;
        check_outputs("reset_mid");
        #1 rst_n = 1'b1;
        step("post_rst",  1, 0, 4'h6, 4'h5);
        step("post_rst2", 1, 1, 4'hA, 4'h3);

        // Exhaustive sweep in shuffled order with occasional idle cycles.
        for (int i = 0; i < 512; i++) order[i] = i;
        for (int i = 511; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(i, 0));
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < 512; i++) begin
            logic [8:0] k;
            k = 9'(order[i]);
            if ($urandom_range(7, 0) == 0) step("idle", 0, 1'($urandom), 4'($urandom), 4'($urandom));
            step("exh", 1, k[8], k[7:4], k[3:0]);
        end

        for (int i = 0; i < 200; i++)
            step("rand", 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
        step("final", 0, 0, 4'h0, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/adder_4bit.md
Name: adder_4bit

Overview:
- Registered ripple-carry binary adder: S = A + B + Cin, producing carry-out and a signed-overflow flag.
- Datapath arithmetic primitive used by small ALU/accumulator blocks in the design.
- Combinational sum is built from a chain of full-adder cells and captured in output registers.
- Latency is one clock.

Parameters:
- WIDTH, 4, operand and sum width in bits (legal range 1..32).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands on a/b/cin are valid this cycle
- cin  input  1  carry-in
- a  input  WIDTH  operand A, unsigned (or two's complement for ovf)
- b  input  WIDTH  operand B
- out_valid  output  1  result registers updated with a new sum this cycle
- cout  output  1  carry-out of MSB
- s  output  WIDTH  sum, modulo 2^WIDTH
- ovf  output  1  two's-complement overflow

Behaviour:
- Reset: rst_n low immediately (asynchronously) forces s=0, cout=0, ovf=0, out_valid=0. Values hold until rst_n is high and a qualifying clock edge occurs.
- Combinational core:
  - Ripple chain of WIDTH full adders. Bit i: s_i = a_i ^ b_i ^ c_i; c_{i+1} = a_i&b_i | a_i&c_i | b_i&c_i; c_0 = cin.
  - Full {cout,s} equals the (WIDTH+1)-bit value a + b + cin, no truncation other than the modulo on s.
  - ovf = c_WIDTH ^ c_{WIDTH-1}, which is 1 when operands share a sign bit and the sum sign differs.
- Register stage: on a rising clk with rst_n high:
  - If in_valid=1: s, cout, ovf load the combinational result; out_valid<=1.
  - If in_valid=0: s, cout, ovf hold their previous values; out_valid<=0.
- Latency: exactly 1 cycle from in_valid sample to out_valid/result.
- Throughput: one operation per cycle; back-to-back valid inputs produce back-to-back results.
- No backpressure; results are never stalled or dropped.
- Boundaries:
  - All-ones + all-ones + cin=1 gives s=all-ones, cout=1.
  - Zero + zero + cin=1 gives s=1, cout=0.
  - Wrap-around is silent except through cout/ovf.
- Reset mid-operation: a pending captured result is discarded and outputs clear at once. The first post-reset in_valid is processed normally.
- X/unknown inputs when in_valid=0 must not disturb held outputs.

Test Plan:
- Reset and zero add:
  - Assert rst_n=0 -> s=0, cout=0, ovf=0, out_valid=0 without a clock edge.
  - Release; apply in_valid=1, cin=0, a=0, b=0 -> next cycle s=0, cout=0, ovf=0, out_valid=1.
- Basic adds, back to back with in_valid=1 (cin, a, b -> s, cout, ovf), each result one cycle after its inputs, out_valid=1 throughout:
  - cin=0, a=2, b=3 -> s=5, cout=0, ovf=0
  - cin=1, a=2, b=3 -> s=6, cout=0, ovf=0
  - cin=1, a=0, b=0 -> s=1, cout=0, ovf=0
- Carry saturation:
  - cin=0, a=4'hF, b=4'hF -> s=4'hE, cout=1, ovf=0
  - cin=1, a=4'hF, b=4'hF -> s=4'hF, cout=1, ovf=0
- Signed overflow:
  - a=7, b=1, cin=0 -> s=8, cout=0, ovf=1
  - a=8, b=8, cin=0 -> s=0, cout=1, ovf=1
- Hold and async reset:
  - After a=2, b=3 result, drop in_valid and drive a=b=4'hX -> s stays 5, out_valid=0.
  - Pulse rst_n low between clock edges -> outputs clear immediately.
- Exhaustive self-check: all 512 (a, b, cin) combinations at WIDTH=4, compared against a reference sum one cycle later.
